posizione_oggetto: RTL and testbench

- Upstream stage for the rectangle/frame hit-test blocks; generates and holds the object centre X_POS/Y_POS that those blocks compare against the scan coordinates.
- Samples four direction buttons once per frame and moves the centre with a simple acceleration profile.
- X wraps modulo the screen width, matching the hit-test wrap handling; Y clamps so the whole rectangle stays on screen.
- Outputs are registered and stable for an entire frame.

---
 rtl/posizione_pkg.sv | 85 ++++++++
 rtl/sincro_pulsante.sv | 56 +++++
 rtl/posizione_oggetto.sv | 148 ++++++++++++++
 tb/tb_posizione_oggetto.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/posizione_pkg.sv
// posizione_pkg: shared screen constants, axis FSM / direction types and the
// per-frame axis step helper used by posizione_oggetto.
package posizione_pkg;

  localparam int H_SCHERMO = 1280;
  localparam int V_SCHERMO = 1024;
  localparam int STEP_W    = 4;
  localparam int POS_W     = 11;

  typedef enum logic [1:0] {FERMO, ACCEL, CRUISE} stato_asse_t;
  typedef enum logic [1:0] {NEG, NONE, POS} dir_t;

  // Result of one frame of an axis FSM: next state, next step, latched
  // direction and how many pixels to move this frame (0 = no move).
  typedef struct packed {
    stato_asse_t         stato;
    logic [STEP_W-1:0]   passo;
    dir_t                dir;
    logic [STEP_W-1:0]   mossa;
  } asse_t;

  // Two opposing buttons collapse to a single direction; both pressed cancel.
  function automatic dir_t dir_da_pulsanti(input logic neg, input logic pos);
    dir_t d;
    case ({neg, pos})
      2'b10:   d = NEG;
      2'b01:   d = POS;
      default: d = NONE;
    endcase
    return d;
  endfunction

  // Acceleration profile: FERMO starts at the minimum step, ACCEL grows the
  // step by one per frame until the maximum (CRUISE), releasing goes back to
  // FERMO and reversing restarts the ramp in the new direction.
  function automatic asse_t avanza_asse(input stato_asse_t       stato,
                                        input logic [STEP_W-1:0] passo,
                                        input dir_t              dir_lat,
                                        input dir_t              dir_in,
                                        input logic [STEP_W-1:0] p_min,
                                        input logic [STEP_W-1:0] p_max);
    asse_t             r;
    logic [STEP_W-1:0] nxt;
    r.stato = stato;
    r.passo = passo;
    r.dir   = dir_lat;
    r.mossa = '0;
    nxt     = passo + 1'b1;
    case (stato)
      FERMO: begin
        r.passo = p_min;
        if (dir_in != NONE) begin
          r.stato = ACCEL;
          r.dir   = dir_in;
          r.mossa = p_min;
        end
      end
      ACCEL, CRUISE: begin
        if (dir_in == NONE) begin
          r.stato = FERMO;
          r.passo = p_min;
        end else if (dir_in != dir_lat) begin
          r.stato = ACCEL;
          r.passo = p_min;
          r.dir   = dir_in;
          r.mossa = p_min;
        end else if (stato == CRUISE) begin
          r.mossa = p_max;
        end else begin
          r.passo = nxt;
          r.mossa = nxt;
          if (nxt >= p_max) begin
            r.stato = CRUISE;
          end
        end
      end
      default: begin
        r.stato = FERMO;
        r.passo = p_min;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sincro_pulsante.sv
// sincro_pulsante: 2-flop synchronizer for one raw push-button.
// With DEBOUNCE_EN defined, the synchronized level is additionally filtered:
// it only follows the input after DEB_CYCLES consecutive differing cycles.
module sincro_pulsante #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn
);

  logic sync_a;
  logic sync_b;

  // Two-stage synchronizer bringing the asynchronous button into clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FINE = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             livello;

  // Count consecutive cycles of disagreement; any bounce back clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      livello <= 1'b0;
    end else if (sync_b != livello) begin
      if (cnt == CNT_FINE) begin
        livello <= sync_b;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign btn = livello;
`else
  assign btn = sync_b;
`endif

endmodule

// File: rtl/posizione_oggetto.sv
// posizione_oggetto: per-frame object centre generator for the hit-test blocks.
// X wraps modulo H, Y clamps to [ALT2, V-1-ALT2]; outputs change only on the
// clock edge that samples FRAME_TICK. Optional button debounce: DEBOUNCE_EN.
module posizione_oggetto
  import posizione_pkg::*;
#(
  parameter int H          = H_SCHERMO,
  parameter int V          = V_SCHERMO,
  parameter int ALT2       = 50,
  parameter int X_INIT     = 640,
  parameter int Y_INIT     = 512,
  parameter int PASSO_MIN  = 2,
  parameter int PASSO_MAX  = 8,
  parameter int DEB_CYCLES = 65536
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FRAME_TICK,
  input  logic             BTN_SX,
  input  logic             BTN_DX,
  input  logic             BTN_SU,
  input  logic             BTN_GIU,
  output logic [POS_W-1:0] X_POS,
  output logic [POS_W-1:0] Y_POS,
  output logic             IN_MOTO
);

  localparam logic [11:0]       H12     = 12'(H);
  localparam logic [11:0]       Y_MAX12 = 12'(V - 1 - ALT2);
  localparam logic [11:0]       Y_MIN12 = 12'(ALT2);
  localparam logic [POS_W-1:0]  X_RST   = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]  Y_RST   = POS_W'(Y_INIT);
  localparam logic [STEP_W-1:0] P_MIN   = STEP_W'(PASSO_MIN);
  localparam logic [STEP_W-1:0] P_MAX   = STEP_W'(PASSO_MAX);

  logic btn_sx;
  logic btn_dx;
  logic btn_su;
  logic btn_giu;

  sincro_pulsante #(.DEB_CYCLES(DEB_CYCLES)) u_sx (
    .clk(CLK), .rst(RST), .btn_raw(BTN_SX), .btn(btn_sx)
  );
  sincro_pulsante #(.DEB_CYCLES(DEB_CYCLES)) u_dx (
    .clk(CLK), .rst(RST), .btn_raw(BTN_DX), .btn(btn_dx)
  );
  sincro_pulsante #(.DEB_CYCLES(DEB_CYCLES)) u_su (
    .clk(CLK), .rst(RST), .btn_raw(BTN_SU), .btn(btn_su)
  );
  sincro_pulsante #(.DEB_CYCLES(DEB_CYCLES)) u_giu (
    .clk(CLK), .rst(RST), .btn_raw(BTN_GIU), .btn(btn_giu)
  );

  stato_asse_t       stato_x;
  stato_asse_t       stato_y;
  logic [STEP_W-1:0] passo_x;
  logic [STEP_W-1:0] passo_y;
  dir_t              dir_x_lat;
  dir_t              dir_y_lat;

  dir_t              dir_x;
  dir_t              dir_y;
  asse_t             nx;
  asse_t             ny;

  logic [11:0]       x_ext;
  logic [11:0]       y_ext;
  logic [11:0]       sx12;
  logic [11:0]       sy12;
  logic [11:0]       x_calc;
  logic [11:0]       y_calc;
  logic [POS_W-1:0]  x_nuovo;
  logic [POS_W-1:0]  y_nuovo;

  // Next axis FSM step for both axes; up is the negative Y direction.
  always_comb begin
    dir_x = dir_da_pulsanti(btn_sx, btn_dx);
    dir_y = dir_da_pulsanti(btn_su, btn_giu);
    nx    = avanza_asse(stato_x, passo_x, dir_x_lat, dir_x, P_MIN, P_MAX);
    ny    = avanza_asse(stato_y, passo_y, dir_y_lat, dir_y, P_MIN, P_MAX);
  end

  // X candidate: add/subtract the step in 12 bits and fold back into 0..H-1.
  always_comb begin
    x_ext  = {1'b0, X_POS};
    sx12   = {8'b0, nx.mossa};
    x_calc = x_ext;
    if (nx.dir == POS) begin
      x_calc = x_ext + sx12;
      if (x_calc >= H12) begin
        x_calc = x_calc - H12;
      end
    end else if (nx.dir == NEG) begin
      if (x_ext < sx12) begin
        x_calc = x_ext + H12 - sx12;
      end else begin
        x_calc = x_ext - sx12;
      end
    end
    x_nuovo = x_calc[POS_W-1:0];
  end

  // Y candidate: move by the step but saturate so the rectangle stays visible.
  always_comb begin
    y_ext  = {1'b0, Y_POS};
    sy12   = {8'b0, ny.mossa};
    y_calc = y_ext;
    if (ny.dir == POS) begin
      y_calc = y_ext + sy12;
      if (y_calc > Y_MAX12) begin
        y_calc = Y_MAX12;
      end
    end else if (ny.dir == NEG) begin
      if (y_ext < Y_MIN12 + sy12) begin
        y_calc = Y_MIN12;
      end else begin
        y_calc = y_ext - sy12;
      end
    end
    y_nuovo = y_calc[POS_W-1:0];
  end

  // Axis FSMs and registered position/motion outputs, advanced once per frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stato_x   <= FERMO;
      stato_y   <= FERMO;
      passo_x   <= P_MIN;
      passo_y   <= P_MIN;
      dir_x_lat <= NONE;
      dir_y_lat <= NONE;
      X_POS     <= X_RST;
      Y_POS     <= Y_RST;
      IN_MOTO   <= 1'b0;
    end else if (FRAME_TICK) begin
      stato_x   <= nx.stato;
      stato_y   <= ny.stato;
      passo_x   <= nx.passo;
      passo_y   <= ny.passo;
      dir_x_lat <= nx.dir;
      dir_y_lat <= ny.dir;
      X_POS     <= x_nuovo;
      Y_POS     <= y_nuovo;
      IN_MOTO   <= (x_nuovo != X_POS) || (y_nuovo != Y_POS);
    end
  end

endmodule

// File: tb/tb_posizione_oggetto.sv
// tb_posizione_oggetto: directed bench for posizione_oggetto with
// hand-computed positions; includes a glitch case when DEBOUNCE_EN is defined.
module tb_posizione_oggetto;

  localparam int DEB    = 8;
  localparam int SETTLE = DEB + 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FRAME_TICK = 1'b0;
  logic        BTN_SX = 1'b0;
  logic        BTN_DX = 1'b0;
  logic        BTN_SU = 1'b0;
  logic        BTN_GIU = 1'b0;
  logic [10:0] X_POS;
  logic [10:0] Y_POS;
  logic        IN_MOTO;

  int total = 0;
  int bad   = 0;

  posizione_oggetto #(.DEB_CYCLES(DEB)) dut (
    .CLK(CLK),
    .RST(RST),
    .FRAME_TICK(FRAME_TICK),
    .BTN_SX(BTN_SX),
    .BTN_DX(BTN_DX),
    .BTN_SU(BTN_SU),
    .BTN_GIU(BTN_GIU),
    .X_POS(X_POS),
    .Y_POS(Y_POS),
    .IN_MOTO(IN_MOTO)
  );

  always #5 CLK = ~CLK;

  // Set the four buttons and let them propagate through the synchronizers.
  task automatic applyStimulus(input logic sx, input logic dx,
                               input logic su, input logic giu);
    @(negedge CLK);
    BTN_SX  = sx;
    BTN_DX  = dx;
    BTN_SU  = su;
    BTN_GIU = giu;
    repeat (SETTLE) @(negedge CLK);
  endtask

  // One-cycle frame pulse; outputs are updated by the following negedge.
  task automatic tickFrame();
    @(negedge CLK);
    FRAME_TICK = 1'b1;
    @(negedge CLK);
    FRAME_TICK = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int ex, input int ey,
                             input logic em);
    total++;
    assert (X_POS === 11'(ex)) else begin
      bad++;
      $error("[TB] FAIL %s X_POS got=%0d exp=%0d", tag, X_POS, ex);
    end
    total++;
    assert (Y_POS === 11'(ey)) else begin
      bad++;
      $error("[TB] FAIL %s Y_POS got=%0d exp=%0d", tag, Y_POS, ey);
    end
    total++;
    assert (IN_MOTO === em) else begin
      bad++;
      $error("[TB] FAIL %s IN_MOTO got=%0b exp=%0b", tag, IN_MOTO, em);
    end
  endtask

  int ramp_x [10] = '{642, 645, 649, 654, 660, 667, 675, 683, 691, 699};

  initial begin
    $display("[TB] start");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("reset", 640, 512, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tickFrame();
      checkOutput("idle", 640, 512, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tickFrame();
      checkOutput($sformatf("ramp%0d", i), ramp_x[i], 512, 1'b1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("release", 699, 512, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 75; i++) tickFrame();
    checkOutput("to_1278", 1278, 512, 1'b1);
    tickFrame();
    checkOutput("wrap_right", 6, 512, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("reversal", 4, 512, 1'b1);
    tickFrame();
    checkOutput("left_step3", 1, 512, 1'b1);
    tickFrame();
    checkOutput("wrap_left", 1277, 512, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("stop_1277", 1277, 512, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tickFrame();
    checkOutput("tap_1279", 1279, 512, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tickFrame();
    checkOutput("tap_wrap_1", 1, 512, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tickFrame();
    checkOutput("tap_3", 3, 512, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("hold_3", 3, 512, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("left_from_3", 1, 512, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tickFrame();
    checkOutput("both_x_1", 1, 512, 1'b0);
    tickFrame();
    checkOutput("both_x_2", 1, 512, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tickFrame();
    checkOutput("after_both", 3, 512, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tickFrame();
    checkOutput("y_ramp", 3, 547, 1'b1);
    for (int i = 0; i < 53; i++) tickFrame();
    checkOutput("y_971", 3, 971, 1'b1);
    tickFrame();
    checkOutput("y_clamp", 3, 973, 1'b1);
    tickFrame();
    checkOutput("y_sat", 3, 973, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tickFrame();
    checkOutput("y_reverse", 3, 971, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("y_stop", 3, 971, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    RST        = 1'b1;
    FRAME_TICK = 1'b1;
    @(negedge CLK);
    RST        = 1'b0;
    FRAME_TICK = 1'b0;
    checkOutput("rst_vs_tick", 640, 512, 1'b0);
    repeat (SETTLE) @(negedge CLK);
    tickFrame();
    checkOutput("after_rst", 642, 512, 1'b1);

`ifdef DEBOUNCE_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickFrame();
    checkOutput("deb_idle", 642, 512, 1'b0);
    @(negedge CLK);
    BTN_SU = 1'b1;
    repeat (5) @(negedge CLK);
    BTN_SU = 1'b0;
    repeat (SETTLE) @(negedge CLK);
    tickFrame();
    checkOutput("deb_glitch", 642, 512, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tickFrame();
    checkOutput("deb_held", 642, 510, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
